// File: rtl/safe_counter_pkg.sv
// safe_counter_pkg: shared constants and types for the safe binary counter.
//   CLK_HZ      board clock frequency (50 MHz)
//   CNT_W       free-running counter width
//   LED_W       number of LED outputs
//   LED_LSB     lowest counter bit shown on the LEDs
//   SYNC_STAGES reset synchronizer depth (minimum 2)
package safe_counter_pkg;

  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned CNT_W       = 32;
  localparam int unsigned LED_W       = 4;
  localparam int unsigned LED_LSB     = 23;
  localparam int unsigned SYNC_STAGES = 2;

  typedef logic [CNT_W-1:0] count_t;
  typedef logic [LED_W-1:0] led_t;

endpackage

// File: rtl/safe_counter_counter.sv
// safe_counter_counter: free-running binary counter with synchronous
// active-low reset; exposes only the LED slice of the count.
// Ports:
//   clk_i    board clock
//   rst_ni   synchronized active-low reset
//   slice_o  count[LED_LSB +: LED_W], combinational from the count register
module safe_counter_counter
  import safe_counter_pkg::*;
#(
  parameter int unsigned CNT_W   = safe_counter_pkg::CNT_W,
  parameter int unsigned LED_W   = safe_counter_pkg::LED_W,
  parameter int unsigned LED_LSB = safe_counter_pkg::LED_LSB
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [LED_W-1:0] slice_o
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;

  // Wraps modulo 2^CNT_W with no flag and no stall.
  always_comb begin
    count_d = count + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

  assign slice_o = count[LED_LSB +: LED_W];

endmodule

// File: rtl/safe_counter_reset_bridge.sv
// reset_bridge: synchronizes the raw asynchronous pushbutton reset into clk.
// The chain has no reset of its own; the flops rely on the FPGA configuration
// value of 0 so the internal reset is asserted from power-up.
// Ports:
//   clk_i       board clock
//   btn_rst_ni  raw pushbutton reset, active-low, asynchronous to clk_i
//   rst_n       synchronized active-low reset, changes only on clk_i edges
module reset_bridge
  import safe_counter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = safe_counter_pkg::SYNC_STAGES
) (
  input  logic clk_i,
  input  logic btn_rst_ni,
  output logic rst_n
);

  localparam int unsigned TAIL = SYNC_STAGES - 1;

  logic            metareg;
  logic [TAIL-1:0] stage_q;

  // Shift left: metareg enters at bit 0, the oldest sample leaves the top.
  always_ff @(posedge clk_i) begin
    metareg <= btn_rst_ni;
    stage_q <= TAIL'({stage_q, metareg});
  end

  assign rst_n = stage_q[TAIL-1];

endmodule

// File: rtl/safe_counter_top.sv
// safe_counter_top: FPGA top for the safe binary counter.
// Conditions the pushbutton reset, runs a free-running counter from the
// 50 MHz board clock and shows a slow slice of it on the LEDs.
// Optional build macro LED_GRAY_EN: LEDs show the Gray code of the slice
// (s ^ (s >> 1)) instead of the plain binary slice.
// Ports:
//   clk        board clock, 50 MHz
//   btn_rst_n  raw pushbutton reset, active-low, asynchronous
//   leds       LED drive, active-high
module safe_counter_top
  import safe_counter_pkg::*;
#(
  parameter int unsigned CNT_W       = safe_counter_pkg::CNT_W,
  parameter int unsigned LED_W       = safe_counter_pkg::LED_W,
  parameter int unsigned LED_LSB     = safe_counter_pkg::LED_LSB,
  parameter int unsigned SYNC_STAGES = safe_counter_pkg::SYNC_STAGES
) (
  input  logic             clk,
  input  logic             btn_rst_n,
  output logic [LED_W-1:0] leds
);

  logic             rst_n;
  logic [LED_W-1:0] slice;

  reset_bridge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_reset_bridge (
    .clk_i     (clk),
    .btn_rst_ni(btn_rst_n),
    .rst_n     (rst_n)
  );

  safe_counter_counter #(
    .CNT_W  (CNT_W),
    .LED_W  (LED_W),
    .LED_LSB(LED_LSB)
  ) u_counter (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .slice_o(slice)
  );

`ifdef LED_GRAY_EN
  assign leds = slice ^ (slice >> 1);
`else
  assign leds = slice;
`endif

endmodule

// File: tb/tb_safe_counter_top.sv
module tb_safe_counter_top;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       btn_rst_n = 1'b0;
  logic [3:0] leds;

  int errors = 0;
  int checks = 0;

  // Reference model: reset is the button value seen SS-1 edges earlier;
  // count is reset-or-increment arithmetic on a 32-bit value.
  bit          btn_hist[$];
  bit          m_rst = 1'b0;
  logic [31:0] m_count = '0;
  logic [31:0] force_val;

  safe_counter_top #(
    .CNT_W      (32),
    .LED_W      (4),
    .LED_LSB    (23),
    .SYNC_STAGES(SS)
  ) dut (
    .clk      (clk),
    .btn_rst_n(btn_rst_n),
    .leds     (leds)
  );

  always #10 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] led_of(input logic [31:0] c);
    logic [3:0] s;
    s = 4'((c / 32'h0080_0000) % 16);
`ifdef LED_GRAY_EN
    return s ^ (s >> 1);
`else
    return s;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit do_chk);
    @(posedge clk);
    m_count = m_rst ? m_count + 32'd1 : 32'd0;
    btn_hist.push_back(btn_rst_n);
    if (btn_hist.size() > 8) void'(btn_hist.pop_front());
    m_rst = (btn_hist.size() >= SS) ? btn_hist[btn_hist.size() - SS] : 1'b0;
    #1;
    if (do_chk) begin
      chk("rst_n", {31'd0, dut.u_reset_bridge.rst_n}, {31'd0, m_rst});
      chk("count", dut.u_counter.count, m_count);
      chk("leds", {28'd0, leds}, {28'd0, led_of(m_count)});
    end
  endtask

  task automatic load(input logic [31:0] v);
    force_val = v;
    force dut.u_counter.count = force_val;
    #1;
    release dut.u_counter.count;
    m_count = v;
    chk("load", dut.u_counter.count, v);
  endtask

  initial begin
    // Power-up: button held low for 100 ns.
    for (int i = 0; i < 5; i++) tick(i >= 2);
    chk("pwr_leds", {28'd0, leds}, 32'd0);

    // Off-grid release at 103 ns.
    #12;
    btn_rst_n = 1'b1;
    #1;
    chk("rst_at_release", {31'd0, dut.u_reset_bridge.rst_n}, 32'd0);
    tick(1'b1);
    chk("rst_after_1edge", {31'd0, dut.u_reset_bridge.rst_n}, 32'd0);
    tick(1'b1);
    chk("rst_after_2edges", {31'd0, dut.u_reset_bridge.rst_n}, 32'd1);
    tick(1'b1);
    chk("first_incr", dut.u_counter.count, 32'd1);
    for (int i = 0; i < 10; i++) tick(1'b1);

    // Bit 23 sets 16 cycles after loading 0x007FFFF0.
    load(32'h007F_FFF0);
    for (int i = 1; i <= 100; i++) begin
      tick(1'b1);
      if (i == 15) chk("leds_before_b23", {28'd0, leds}, 32'd0);
      if (i == 16) chk("leds_at_b23", {28'd0, leds}, 32'd1);
    end

    // Counter wrap.
    load(32'hFFFF_FFFE);
    chk("leds_pre_wrap", {28'd0, leds}, {28'd0, led_of(32'hFFFF_FFFE)});
    tick(1'b1);
    chk("wrap_ffffffff", dut.u_counter.count, 32'hFFFF_FFFF);
    tick(1'b1);
    chk("wrap_zero", dut.u_counter.count, 32'h0000_0000);
    chk("wrap_leds", {28'd0, leds}, 32'd0);
    tick(1'b1);
    chk("wrap_one", dut.u_counter.count, 32'h0000_0001);

    // Mid-run reset for 3 cycles.
    for (int i = 0; i < 20; i++) tick(1'b1);
    #5;
    btn_rst_n = 1'b0;
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    chk("midrst_held", dut.u_counter.count, 32'd0);
    #5;
    btn_rst_n = 1'b1;
    tick(1'b1);
    tick(1'b1);
    chk("midrst_restart0", dut.u_counter.count, 32'd0);
    tick(1'b1);
    chk("midrst_restart1", dut.u_counter.count, 32'd1);

    // Slice step 1 -> 2 (Gray build shows 0001 -> 0011).
    load(32'h00FF_FFFF);
    chk("slice1_leds", {28'd0, leds}, {28'd0, led_of(32'h00FF_FFFF)});
    tick(1'b1);
    chk("slice2_leds", {28'd0, leds}, {28'd0, led_of(32'h0100_0000)});

    // Randomized mix of boundary loads, free running and reset pulses.
    for (int it = 0; it < 40; it++) begin
      int unsigned r;
      r = $urandom_range(0, 3);
      if (r == 0) begin
        load(($urandom_range(0, 511) << 23) - $urandom_range(1, 12));
      end
      for (int n = 0; n < int'($urandom_range(1, 30)); n++) tick(1'b1);
      if (r == 1) begin
        #($urandom_range(1, 17));
        btn_rst_n = 1'b0;
        for (int n = 0; n < int'($urandom_range(1, 4)); n++) tick(1'b1);
        #($urandom_range(1, 17));
        btn_rst_n = 1'b1;
        for (int n = 0; n < 4; n++) tick(1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
